// File: rtl/aq_ifu_inv_sched_if.sv
// Request/ack and array-write-port bundle for the IFU invalidation scheduler.
interface aq_ifu_inv_sched_if #(
    parameter int unsigned ICACHE_IDX_W = 8,
    parameter int unsigned BHT_IDX_W    = 9
);
    logic                    ifu_inv_rst_req;
    logic                    cp0_icache_inv_req;
    logic                    cp0_bht_inv_req;
    logic                    icache_inv_stall;
    logic                    icache_inv_wen;
    logic [ICACHE_IDX_W-1:0] icache_inv_idx;
    logic                    bht_inv_wen;
    logic [BHT_IDX_W-1:0]    bht_inv_idx;
    logic                    inv_rst_done;
    logic                    cp0_icache_inv_ack;
    logic                    cp0_bht_inv_ack;
    logic                    inv_busy;

    modport master (
        output ifu_inv_rst_req, cp0_icache_inv_req, cp0_bht_inv_req, icache_inv_stall,
        input  icache_inv_wen, icache_inv_idx, bht_inv_wen, bht_inv_idx,
               inv_rst_done, cp0_icache_inv_ack, cp0_bht_inv_ack, inv_busy
    );

    modport slave (
        input  ifu_inv_rst_req, cp0_icache_inv_req, cp0_bht_inv_req, icache_inv_stall,
        output icache_inv_wen, icache_inv_idx, bht_inv_wen, bht_inv_idx,
               inv_rst_done, cp0_icache_inv_ack, cp0_bht_inv_ack, inv_busy
    );
endinterface

// File: rtl/aq_ifu_inv_sched.sv
// Whole-array icache tag / BHT invalidation sequencer with reset, CP0-icache and CP0-BHT sources.
// Optional BHT walk is enabled by defining AQ_IFU_BHT_INV_EN.
module aq_ifu_inv_sched #(
    parameter int unsigned ICACHE_IDX_W = 8,
    parameter int unsigned BHT_IDX_W    = 9
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    aq_ifu_inv_sched_if.slave bus
);
    localparam int unsigned IC_W  = ICACHE_IDX_W;
    localparam int unsigned BHT_W = BHT_IDX_W;

`ifdef AQ_IFU_BHT_INV_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IC_WALK  = 2'd1,
        ST_BHT_WALK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IC_WALK  = 2'd1,
        ST_DONE     = 2'd3
    } state_t;
`endif

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RST  = 2'd1,
        SRC_IC   = 2'd2,
        SRC_BHT  = 2'd3
    } src_t;

    state_t          state;
    src_t            src;
    logic [IC_W-1:0] ic_cnt;
    logic            pend_rst;
    logic            rst_again;
    logic            rst_done_q;
    logic            ic_ack_q;
    logic            bht_ack_q;

    logic            pend_ic;
    logic            pend_bht;
    logic            ic_wen;
    logic            rst_live;

    // Software levels are masked in their ack cycle so a still-high request is not re-taken.
    assign pend_ic  = bus.cp0_icache_inv_req & ~ic_ack_q;
    assign pend_bht = bus.cp0_bht_inv_req & ~bht_ack_q;
    assign ic_wen   = (state == ST_IC_WALK) & ~bus.icache_inv_stall;
    // A reset request landing while a reset walk is owned must trigger another full walk.
    assign rst_live = (src == SRC_RST) | ((state == ST_IDLE) & pend_rst);

`ifdef AQ_IFU_BHT_INV_EN
    logic [BHT_W-1:0] bht_cnt;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            bht_cnt <= '0;
        end else if (state == ST_BHT_WALK) begin
            bht_cnt <= bht_cnt + BHT_W'(1);
        end
    end

    assign bus.bht_inv_wen = (state == ST_BHT_WALK);
    assign bus.bht_inv_idx = bht_cnt;
`else
    assign bus.bht_inv_wen = 1'b0;
    assign bus.bht_inv_idx = BHT_W'(0);
`endif

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state      <= ST_IDLE;
            src        <= SRC_NONE;
            ic_cnt     <= '0;
            pend_rst   <= 1'b0;
            rst_again  <= 1'b0;
            rst_done_q <= 1'b0;
            ic_ack_q   <= 1'b0;
            bht_ack_q  <= 1'b0;
        end else begin
            rst_done_q <= 1'b0;
            ic_ack_q   <= 1'b0;
            bht_ack_q  <= 1'b0;

            if (bus.ifu_inv_rst_req) begin
                pend_rst <= 1'b1;
                if (rst_live) begin
                    rst_again <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pend_rst) begin
                        src   <= SRC_RST;
                        state <= ST_IC_WALK;
                    end else if (pend_ic) begin
                        src   <= SRC_IC;
                        state <= ST_IC_WALK;
                    end else if (pend_bht) begin
                        src   <= SRC_BHT;
`ifdef AQ_IFU_BHT_INV_EN
                        state <= ST_BHT_WALK;
`else
                        state <= ST_DONE;
`endif
                    end
                end
                ST_IC_WALK: begin
                    if (ic_wen) begin
                        ic_cnt <= ic_cnt + IC_W'(1);
                        if (ic_cnt == '1) begin
`ifdef AQ_IFU_BHT_INV_EN
                            state <= (src == SRC_RST) ? ST_BHT_WALK : ST_DONE;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef AQ_IFU_BHT_INV_EN
                ST_BHT_WALK: begin
                    if (bht_cnt == '1) begin
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    case (src)
                        SRC_RST: begin
                            rst_done_q <= 1'b1;
                            pend_rst   <= rst_again | bus.ifu_inv_rst_req;
                            rst_again  <= 1'b0;
                        end
                        SRC_IC:  ic_ack_q  <= 1'b1;
                        SRC_BHT: bht_ack_q <= 1'b1;
                        default: ;
                    endcase
                    src   <= SRC_NONE;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.icache_inv_wen     = ic_wen;
    assign bus.icache_inv_idx     = ic_cnt;
    assign bus.inv_rst_done       = rst_done_q;
    assign bus.cp0_icache_inv_ack = ic_ack_q;
    assign bus.cp0_bht_inv_ack    = bht_ack_q;
    assign bus.inv_busy           = (state != ST_IDLE);
endmodule

// File: tb/tb_aq_ifu_inv_sched.sv
// Scoreboard bench for aq_ifu_inv_sched: a request-level model queues the expected write/ack
// stream; a negedge monitor pops and compares every write and completion the DUT emits.
module tb_aq_ifu_inv_sched;
    localparam int unsigned ICW  = 8;
    localparam int unsigned BHW  = 9;
    localparam int          IC_N = 1 << ICW;
    localparam int          BH_N = 1 << BHW;
`ifdef AQ_IFU_BHT_INV_EN
    localparam bit BHT_EN = 1'b1;
`else
    localparam bit BHT_EN = 1'b0;
`endif

    typedef enum int {EV_IC = 0, EV_BHT = 1, EV_RST_DONE = 2, EV_IC_ACK = 3, EV_BHT_ACK = 4} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       idx;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    aq_ifu_inv_sched_if #(.ICACHE_IDX_W(ICW), .BHT_IDX_W(BHW)) bus();

    aq_ifu_inv_sched #(.ICACHE_IDX_W(ICW), .BHT_IDX_W(BHW)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  m_rst, m_ic, m_bht;
    bit  rand_stall = 1'b0;
    int  req_cyc, first_ic_cyc, first_bht_cyc, done_cyc, ic_ack_cyc, bht_ack_cyc, ack_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void push(input ev_kind_t k, input int idx);
        ev_t e;
        e.kind = k;
        e.idx  = idx;
        exp_q.push_back(e);
    endfunction

    // Model: one walk at a time, next chosen by priority rst > icache > bht once the previous completes.
    function automatic void sched();
        if (exp_q.size() != 0) return;
        if (m_rst) begin
            m_rst = 1'b0;
            for (int i = 0; i < IC_N; i++) push(EV_IC, i);
            if (BHT_EN) for (int i = 0; i < BH_N; i++) push(EV_BHT, i);
            push(EV_RST_DONE, 0);
        end else if (m_ic) begin
            m_ic = 1'b0;
            for (int i = 0; i < IC_N; i++) push(EV_IC, i);
            push(EV_IC_ACK, 0);
        end else if (m_bht) begin
            m_bht = 1'b0;
            if (BHT_EN) for (int i = 0; i < BH_N; i++) push(EV_BHT, i);
            push(EV_BHT_ACK, 0);
        end
    endfunction

    task automatic expect_ev(input string name, input ev_kind_t k, input int idx);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event kind %0d idx %0d, expected none (cycle %0d)", name, int'(k), idx, cyc);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, int'(k), int'(e.kind));
            chk({name, "_idx"}, idx, e.idx);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_stall) bus.icache_inv_stall = ($urandom_range(0, 3) == 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.icache_inv_wen) begin
                if (bus.icache_inv_idx == '0) first_ic_cyc = cyc;
                chk("busy_during_ic_wen", int'(bus.inv_busy), 1);
                chk("wen_exclusive", int'(bus.bht_inv_wen), 0);
                expect_ev("ic_write", EV_IC, int'(bus.icache_inv_idx));
            end
            if (bus.bht_inv_wen) begin
                if (bus.bht_inv_idx == '0) first_bht_cyc = cyc;
                chk("busy_during_bht_wen", int'(bus.inv_busy), 1);
                expect_ev("bht_write", EV_BHT, int'(bus.bht_inv_idx));
            end
            if (bus.inv_rst_done) begin
                done_cyc = cyc;
                ack_seen++;
                expect_ev("rst_done", EV_RST_DONE, 0);
                sched();
            end
            if (bus.cp0_icache_inv_ack) begin
                ic_ack_cyc = cyc;
                ack_seen++;
                bus.cp0_icache_inv_req = 1'b0;
                expect_ev("ic_ack", EV_IC_ACK, 0);
                sched();
            end
            if (bus.cp0_bht_inv_ack) begin
                bht_ack_cyc = cyc;
                ack_seen++;
                bus.cp0_bht_inv_req = 1'b0;
                expect_ev("bht_ack", EV_BHT_ACK, 0);
                sched();
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.inv_busy && !m_rst && !m_ic && !m_bht) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: idle timeout, %0d events still expected", name, exp_q.size());
    endtask

    task automatic wait_wen(input string name, input bit bht, input int idx);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (bht ? (bus.bht_inv_wen && int'(bus.bht_inv_idx) == idx)
                    : (bus.icache_inv_wen && int'(bus.icache_inv_idx) == idx)) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for write at idx %0d", name, idx);
    endtask

    task automatic pulse_rst_req();
        @(posedge clk); #1;
        bus.ifu_inv_rst_req = 1'b1;
        req_cyc = cyc;
        m_rst = 1'b1;
        sched();
        @(posedge clk); #1;
        bus.ifu_inv_rst_req = 1'b0;
    endtask

    task automatic issue_sw(input bit ic, input bit bht);
        @(posedge clk); #1;
        req_cyc = cyc;
        if (ic)  begin bus.cp0_icache_inv_req = 1'b1; m_ic = 1'b1; end
        if (bht) begin bus.cp0_bht_inv_req = 1'b1; m_bht = 1'b1; end
        sched();
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_ic_wen"},   int'(bus.icache_inv_wen), 0);
        chk({name, "_ic_idx"},   int'(bus.icache_inv_idx), 0);
        chk({name, "_bht_wen"},  int'(bus.bht_inv_wen), 0);
        chk({name, "_bht_idx"},  int'(bus.bht_inv_idx), 0);
        chk({name, "_rst_done"}, int'(bus.inv_rst_done), 0);
        chk({name, "_ic_ack"},   int'(bus.cp0_icache_inv_ack), 0);
        chk({name, "_bht_ack"},  int'(bus.cp0_bht_inv_ack), 0);
        chk({name, "_busy"},     int'(bus.inv_busy), 0);
    endtask

    initial begin
        bus.ifu_inv_rst_req    = 1'b0;
        bus.cp0_icache_inv_req = 1'b0;
        bus.cp0_bht_inv_req    = 1'b0;
        bus.icache_inv_stall   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Power-on style walk, no stall.
        pulse_rst_req();
        wait_idle("rst_walk");
        chk("rst_first_wen_latency", first_ic_cyc - req_cyc, 2);
`ifdef AQ_IFU_BHT_INV_EN
        chk("rst_bht_follows_ic", first_bht_cyc - first_ic_cyc, IC_N);
        chk("rst_done_latency", done_cyc - first_ic_cyc, IC_N + BH_N + 1);
`else
        chk("rst_done_latency", done_cyc - first_ic_cyc, IC_N + 1);
`endif

        // Software icache walk with a 10-cycle stall at index 37.
        issue_sw(1'b1, 1'b0);
        wait_wen("stall_pre", 1'b0, 36);
        @(posedge clk); #1;
        bus.icache_inv_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_wen", int'(bus.icache_inv_wen), 0);
            chk("stall_idx", int'(bus.icache_inv_idx), 37);
        end
        @(posedge clk); #1;
        bus.icache_inv_stall = 1'b0;
        wait_idle("ic_stall_walk");
        chk("ic_first_wen_latency", first_ic_cyc - req_cyc, 1);
        chk("ic_ack_latency_stalled", ic_ack_cyc - first_ic_cyc, IC_N + 1 + 10);

        // Both software requests together: icache first, one idle cycle, then bht.
        issue_sw(1'b1, 1'b1);
        wait_idle("ic_bht_pair");
`ifdef AQ_IFU_BHT_INV_EN
        chk("pair_bht_start_gap", first_bht_cyc - ic_ack_cyc, 1);
        chk("pair_bht_ack_latency", bht_ack_cyc - first_bht_cyc, BH_N + 1);
`else
        chk("pair_bht_ack_gap", bht_ack_cyc - ic_ack_cyc, 2);
`endif

        // BHT-only request latency.
        issue_sw(1'b0, 1'b1);
        wait_idle("bht_only");
`ifdef AQ_IFU_BHT_INV_EN
        chk("bht_first_wen_latency", first_bht_cyc - req_cyc, 1);
        chk("bht_ack_latency", bht_ack_cyc - first_bht_cyc, BH_N + 1);
`else
        chk("bht_ack_latency", bht_ack_cyc - req_cyc, 2);
`endif

        // Reset request mid software walk waits, then walks from index 0.
        issue_sw(1'b1, 1'b0);
        wait_wen("rst_mid_ic", 1'b0, 100);
        pulse_rst_req();
        wait_idle("rst_after_ic");
        chk("rst_after_ic_start_gap", first_ic_cyc - ic_ack_cyc, 1);

        // Reset request re-issued during a reset walk yields a second walk.
        pulse_rst_req();
        wait_wen("rst_rearm", 1'b0, 50);
        pulse_rst_req();
        wait_idle("rst_rearm_walks");

        // Randomised request mixes, stalls and mid-walk reset injections.
        for (int n = 0; n < 6; n++) begin
            int  mask;
            int  inj;
            bit  do_inj;
            mask       = $urandom_range(1, 3);
            rand_stall = bit'($urandom_range(0, 1));
            do_inj     = (mask[0] == 1'b1) && ($urandom_range(0, 1) == 1);
            inj        = $urandom_range(0, IC_N - 1);
            issue_sw(mask[0], mask[1]);
            if (do_inj) begin
                wait_wen("rand_inj", 1'b0, inj);
                pulse_rst_req();
            end
            wait_idle("rand_mix");
        end
        rand_stall = 1'b0;
        @(posedge clk); #1;
        bus.icache_inv_stall = 1'b0;

        // Asynchronous reset mid-walk aborts with no completion.
        pulse_rst_req();
`ifdef AQ_IFU_BHT_INV_EN
        wait_wen("abort_point", 1'b1, 200);
`else
        wait_wen("abort_point", 1'b0, 200);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        m_rst = 1'b0;
        m_ic  = 1'b0;
        m_bht = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ack_seen = 0;
        repeat (20) @(negedge clk);
        check_outputs_zero("post_abort");
        chk("post_abort_acks", ack_seen, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
